// File: rtl/nibble_link_pkg.sv
// nibble_link_pkg: shared constants, FSM states and nibble packing for the nibble link scheduler
package nibble_link_pkg;
  localparam int DEPTH = 8;
  localparam int PTR_W = 4;
  localparam int CRED_W = 4;
  localparam int CRED_PER_BYTE = 2;
  typedef enum logic [1:0] {IDLE, WR0, WR1} state_t;
  function automatic logic [3:0] pack_lo(input logic [7:0] b);
    return {b[5], b[4], b[1], b[0]};
  endfunction
  function automatic logic [3:0] pack_hi(input logic [7:0] b);
    return {b[7], b[6], b[3], b[2]};
  endfunction
endpackage

// File: rtl/nibble_link_sched_if.sv
// nibble_link_sched_if: requester handshakes, credit return and link memory write port
interface nibble_link_sched_if;
  import nibble_link_pkg::*;
  logic in0_valid;
  logic [7:0] in0_data;
  logic in0_ready;
  logic in1_valid;
  logic [7:0] in1_data;
  logic in1_ready;
  logic crd_ret;
  logic mem_w_en;
  logic [PTR_W-1:0] mem_w_addr;
  logic [3:0] mem_w_data;
  logic [PTR_W-1:0] wptr;
  logic [CRED_W-1:0] credits;
  logic grant_id;
  logic busy;
  logic ovf_err;
  modport master (
    output in0_valid, in0_data, in1_valid, in1_data, crd_ret,
    input in0_ready, in1_ready, mem_w_en, mem_w_addr, mem_w_data, wptr, credits, grant_id, busy, ovf_err
  );
  modport slave (
    input in0_valid, in0_data, in1_valid, in1_data, crd_ret,
    output in0_ready, in1_ready, mem_w_en, mem_w_addr, mem_w_data, wptr, credits, grant_id, busy, ovf_err
  );
endinterface

// File: rtl/nibble_link_sched_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter, favouring the requester not granted last
module rr_arb2 (
  input  logic       req0,
  input  logic       req1,
  input  logic       last_grant,
  input  logic       en,
  output logic [1:0] grant
);
  assign grant[0] = en & req0 & (~req1 | last_grant);
  assign grant[1] = en & req1 & (~req0 | ~last_grant);
endmodule

// File: rtl/nibble_link_sched.sv
// nibble_link_sched: arbitrates two byte producers and writes each byte as two nibbles under credit control
module nibble_link_sched
  import nibble_link_pkg::*;
(
  input logic clk,
  input logic rst,
  nibble_link_sched_if.slave bus
);
  state_t state, state_nxt;
  logic [7:0] hold;
  logic last_grant, grant_id, ovf_err, en, accept;
  logic [1:0] gnt;
  logic [PTR_W-1:0] wptr;
  logic [CRED_W-1:0] credits, credits_nxt;
  logic [3:0] wr_data;
  assign en = !rst && state != WR0 && credits >= CRED_W'(CRED_PER_BYTE);
  rr_arb2 u_arb (
    .req0(bus.in0_valid),
    .req1(bus.in1_valid),
    .last_grant(last_grant),
    .en(en),
    .grant(gnt)
  );
  assign accept = |gnt;
  // next state, credit update and write nibble selection
  always_comb begin
    state_nxt = state == WR0 ? WR1 : accept ? WR0 : IDLE;
    credits_nxt = (accept && !bus.crd_ret) ? credits - CRED_W'(CRED_PER_BYTE)
                : (bus.crd_ret && !accept) ? (credits >= CRED_W'(DEPTH - CRED_PER_BYTE) ? CRED_W'(DEPTH)
                                                : credits + CRED_W'(CRED_PER_BYTE))
                : credits;
    wr_data = state == WR0 ? pack_lo(hold) : state == WR1 ? pack_hi(hold) : 4'd0;
  end
  // state, pointer, credits and captured byte
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      hold <= '0;
      last_grant <= 1'b1;
      grant_id <= 1'b0;
      ovf_err <= 1'b0;
      wptr <= '0;
      credits <= CRED_W'(DEPTH);
    end else begin
      state <= state_nxt;
      credits <= credits_nxt;
      ovf_err <= ovf_err | (bus.crd_ret && credits == CRED_W'(DEPTH));
      wptr <= state != IDLE ? wptr + 1'b1 : wptr;
      if (accept) begin
        hold <= gnt[1] ? bus.in1_data : bus.in0_data;
        last_grant <= gnt[1];
        grant_id <= gnt[1];
      end
    end
  end
  assign bus.in0_ready = gnt[0];
  assign bus.in1_ready = gnt[1];
  assign bus.mem_w_en = state != IDLE;
  assign bus.mem_w_addr = wptr;
  assign bus.mem_w_data = wr_data;
  assign bus.wptr = wptr;
  assign bus.credits = credits;
  assign bus.grant_id = grant_id;
  assign bus.busy = state != IDLE;
  assign bus.ovf_err = ovf_err;
endmodule
